fifo_pkt_tx: RTL and testbench

- Write-domain packet transmitter that drives the async FIFO write port (wen/wdata) and honours its registered full flag.
- Collects one packet from an upstream valid/ready stream into a local store-and-forward buffer.
- Emits a length header word followed by the payload words into the FIFO, so the read-domain consumer can frame packets.
- Sits between the write-domain producer and the FIFO write-pointer/memory logic, on the wclk side.

---
 rtl/fifo_pkt_tx.sv | 99 +++++++++
 tb/tb_fifo_pkt_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_tx.sv
// fifo_pkt_tx: store-and-forward packet writer; emits a length header then payload into the async FIFO.
// Define PKT_CHK_EN to append an XOR trailer (header ^ stored payload) after each packet.
module fifo_pkt_tx #(
   parameter int D_W = 16,
   parameter int L_SIZE = 3
) (
   input  logic           wclk,
   input  logic           wrstn,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [D_W-1:0] s_data,
   input  logic           s_last,
   output logic           fifo_wen,
   output logic [D_W-1:0] fifo_wdata,
   input  logic           fifo_full,
   output logic           pkt_sent,
   output logic           trunc_err
);
   localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, HDR = 3'd2, BODY = 3'd3;
   localparam logic [L_SIZE:0] MAX = {1'b1, {L_SIZE{1'b0}}};
`ifdef PKT_CHK_EN
   localparam logic [2:0] CHK = 3'd4;
   logic [D_W-1:0] xr;
`endif
   logic [2:0] state;
   logic [L_SIZE:0] cnt, rd_idx;
   logic trunc, acc, store, body_end, last_wr;
   logic [L_SIZE-1:0] widx;
   logic [D_W-1:0] pbuf [2**L_SIZE];
   assign s_ready = state == IDLE || state == COLLECT;
   assign acc = s_valid && s_ready;
   assign store = acc && (state == IDLE || cnt < MAX);
   assign widx = state == IDLE ? '0 : cnt[L_SIZE-1:0];
   assign body_end = state == BODY && fifo_wen && rd_idx == cnt - 1'b1;
`ifdef PKT_CHK_EN
   assign fifo_wen = (state == HDR || state == BODY || state == CHK) && !fifo_full;
   assign last_wr = state == CHK && fifo_wen;
`else
   assign fifo_wen = (state == HDR || state == BODY) && !fifo_full;
   assign last_wr = body_end;
`endif
   // wdata depends only on registered state, so it holds steady across full stalls
   always_comb begin
      fifo_wdata = state == HDR ? D_W'(cnt) : pbuf[rd_idx[L_SIZE-1:0]];
`ifdef PKT_CHK_EN
      if (state == CHK) fifo_wdata = xr;
`endif
   end
   always_ff @(posedge wclk)
      if (store) pbuf[widx] <= s_data;
   always_ff @(posedge wclk or negedge wrstn)
      if (!wrstn) begin
         state <= IDLE;
         cnt <= '0;
         rd_idx <= '0;
         trunc <= 1'b0;
         pkt_sent <= 1'b0;
         trunc_err <= 1'b0;
`ifdef PKT_CHK_EN
         xr <= '0;
`endif
      end else begin
         pkt_sent <= last_wr;
         trunc_err <= last_wr && trunc;
         case (state)
            IDLE: if (acc) begin
               cnt <= {{L_SIZE{1'b0}}, 1'b1};
               trunc <= 1'b0;
               state <= s_last ? HDR : COLLECT;
            end
            COLLECT: if (acc) begin
               if (cnt < MAX) cnt <= cnt + 1'b1;
               else trunc <= 1'b1;
               if (s_last) state <= HDR;
            end
            HDR: if (fifo_wen) begin
               rd_idx <= '0;
               state <= BODY;
            end
            BODY: if (fifo_wen) begin
               rd_idx <= rd_idx + 1'b1;
`ifdef PKT_CHK_EN
               if (body_end) state <= CHK;
`else
               if (body_end) state <= IDLE;
`endif
            end
`ifdef PKT_CHK_EN
            CHK: if (fifo_wen) state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
`ifdef PKT_CHK_EN
         if (state == IDLE) xr <= acc ? s_data : '0;
         else if (state == COLLECT && store) xr <= xr ^ s_data;
         else if (state == HDR && fifo_wen) xr <= xr ^ D_W'(cnt);
`endif
      end
endmodule

// File: tb/tb_fifo_pkt_tx.sv
// tb_fifo_pkt_tx: randomized and directed checks of fifo_pkt_tx against a queue-based packet model.
module tb_fifo_pkt_tx;
   localparam int MAX = 8;
`ifdef PKT_CHK_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif
   logic wclk = 0, wrstn = 0;
   logic s_valid = 0, s_ready, s_last = 0;
   logic [15:0] s_data = '0, fifo_wdata;
   logic fifo_wen, fifo_full = 0, pkt_sent, trunc_err;
   int compared = 0, mismatched = 0;
   int sent_cnt = 0, trunc_cnt = 0, pair_bad = 0, viol = 0, exp_sent = 0, exp_trunc = 0;
   logic [15:0] got[$], exp[$];

   fifo_pkt_tx #(.D_W(16), .L_SIZE(3)) dut (
      .wclk(wclk), .wrstn(wrstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
      .pkt_sent(pkt_sent), .trunc_err(trunc_err));

   always #5 wclk = ~wclk;

   always @(negedge wclk) begin
      if (fifo_wen) got.push_back(fifo_wdata);
      if (fifo_wen && fifo_full) viol++;
      if (pkt_sent) sent_cnt++;
      if (trunc_err) trunc_cnt++;
      if (trunc_err && !pkt_sent) pair_bad++;
   end

   task automatic clr();
      got.delete();
      exp.delete();
      sent_cnt = 0; trunc_cnt = 0; pair_bad = 0; viol = 0; exp_sent = 0; exp_trunc = 0;
   endtask

   // Model: header = min(n,MAX), then the first min(n,MAX) beats, then optional XOR trailer
   task automatic expect_pkt(input logic [15:0] b[$]);
      int n;
      logic [15:0] x;
      n = b.size() > MAX ? MAX : b.size();
      x = 16'(n);
      exp.push_back(16'(n));
      for (int i = 0; i < n; i++) begin
         exp.push_back(b[i]);
         x = x ^ b[i];
      end
      if (TRL == 1) exp.push_back(x);
      exp_sent++;
      if (b.size() > MAX) exp_trunc++;
   endtask

   task automatic send_beat(input logic [15:0] d, input logic l);
      int t;
      t = 0;
      s_valid = 1; s_data = d; s_last = l;
      @(negedge wclk);
      while (!s_ready && t < 200) begin
         @(negedge wclk);
         t++;
      end
      if (t >= 200) begin
         compared++; mismatched++;
         $display("FAIL beat_accept_timeout: s_ready=%0b after %0d cycles, want 1", s_ready, t);
      end
      @(posedge wclk); #1;
      s_valid = 0; s_last = 0;
   endtask

   task automatic send_pkt(input logic [15:0] b[$], input bit gaps);
      for (int i = 0; i < b.size(); i++) begin
         send_beat(b[i], i == b.size() - 1);
         if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge wclk);
         if (gaps) #1;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (got.size() < exp.size() && t < 500) begin
         @(posedge wclk);
         t++;
      end
      if (t >= 500) begin
         compared++; mismatched++;
         $display("FAIL drain_timeout: got %0d words, want %0d", got.size(), exp.size());
      end
      repeat (4) @(posedge wclk);
      #1;
   endtask

   function automatic int first_diff();
      if (got.size() != exp.size()) return -2;
      foreach (exp[i]) if (got[i] !== exp[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      wrstn = 0;
      repeat (2) @(negedge wclk);
      compared++;
      if ({fifo_wen, pkt_sent, trunc_err, s_ready} !== 4'b0001) begin
         mismatched++;
         $display("FAIL reset_outputs: wen/sent/trunc/ready=%b want 0001", {fifo_wen, pkt_sent, trunc_err, s_ready});
      end
      wrstn = 1;
      @(negedge wclk);
      compared++;
      if ({fifo_wen, s_ready} !== 2'b01) begin
         mismatched++;
         $display("FAIL post_reset_idle: wen/ready=%b want 01", {fifo_wen, s_ready});
      end
      @(posedge wclk); #1;
   endtask

   task automatic test_single();
      int d;
      clr();
      expect_pkt('{16'hA5A5});
      send_pkt('{16'hA5A5}, 0);
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL single_seq: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
      compared++;
      if (sent_cnt != 1 || trunc_cnt != 0) begin
         mismatched++;
         $display("FAIL single_pulses: sent=%0d trunc=%0d want 1 0", sent_cnt, trunc_cnt);
      end
   endtask

   task automatic test_four();
      int d, hi;
      clr();
      hi = 0;
      expect_pkt('{16'h0011, 16'h0022, 16'h0033, 16'h0044});
      send_pkt('{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0);
      if (s_ready) hi++;
      repeat (4 + TRL) begin
         @(posedge wclk); #1;
         if (s_ready) hi++;
      end
      compared++;
      if (hi != 0) begin
         mismatched++;
         $display("FAIL four_ready_low: s_ready high %0d cycles, want 0", hi);
      end
      @(posedge wclk); #1;
      compared++;
      if ({s_ready, pkt_sent} !== 2'b11) begin
         mismatched++;
         $display("FAIL four_end: ready/sent=%b want 11", {s_ready, pkt_sent});
      end
      @(posedge wclk); #1;
      compared++;
      if (pkt_sent !== 1'b0) begin
         mismatched++;
         $display("FAIL four_pulse_width: pkt_sent=%b want 0", pkt_sent);
      end
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL four_seq: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
   endtask

   task automatic test_stall();
      int d;
      clr();
      expect_pkt('{16'h0011, 16'h0022, 16'h0033, 16'h0044});
      send_pkt('{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0);
      @(posedge wclk); #1;
      fifo_full = 1;
      repeat (3) begin
         @(negedge wclk);
         compared++;
         if (fifo_wen !== 1'b0 || fifo_wdata !== 16'h0011) begin
            mismatched++;
            $display("FAIL stall_hold: wen=%b wdata=%h want 0 0011", fifo_wen, fifo_wdata);
         end
      end
      @(posedge wclk); #1;
      fifo_full = 0;
      @(negedge wclk);
      compared++;
      if (fifo_wen !== 1'b1 || fifo_wdata !== 16'h0011) begin
         mismatched++;
         $display("FAIL stall_release: wen=%b wdata=%h want 1 0011", fifo_wen, fifo_wdata);
      end
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1 || viol != 0) begin
         mismatched++;
         $display("FAIL stall_seq: got %0d words diff@%0d viol=%0d, want %0d words viol=0", got.size(), d, viol, exp.size());
      end
   endtask

   task automatic test_trunc();
      logic [15:0] b[$];
      int d;
      clr();
      for (int i = 0; i < 11; i++) b.push_back(16'h0100 + 16'(i));
      expect_pkt(b);
      send_pkt(b, 0);
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL trunc_seq: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
      compared++;
      if (sent_cnt != 1 || trunc_cnt != 1 || pair_bad != 0) begin
         mismatched++;
         $display("FAIL trunc_pulses: sent=%0d trunc=%0d unpaired=%0d want 1 1 0", sent_cnt, trunc_cnt, pair_bad);
      end
   endtask

   task automatic test_mid_reset();
      int d;
      clr();
      send_pkt('{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0);
      repeat (3) @(posedge wclk);
      #1;
      wrstn = 0;
      #1;
      compared++;
      if (fifo_wen !== 1'b0 || got.size() != 3 || got[0] !== 16'h0004 || got[2] !== 16'h0022) begin
         mismatched++;
         $display("FAIL midrst_cut: wen=%b words=%0d want 0 and 3 words 0004,0011,0022", fifo_wen, got.size());
      end
      @(negedge wclk);
      wrstn = 1;
      clr();
      repeat (3) @(negedge wclk);
      compared++;
      if (s_ready !== 1'b1 || got.size() != 0 || sent_cnt != 0) begin
         mismatched++;
         $display("FAIL midrst_idle: ready=%b words=%0d sent=%0d want 1 0 0", s_ready, got.size(), sent_cnt);
      end
      @(posedge wclk); #1;
      expect_pkt('{16'h0077});
      send_pkt('{16'h0077}, 0);
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL midrst_new: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a[$], b[$];
      int d;
      clr();
      a = '{16'hD000, 16'hD001};
      b = '{16'hE000, 16'hE001, 16'hE002};
      expect_pkt(a);
      expect_pkt(b);
      send_pkt(a, 0);
      send_pkt(b, 0);
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL b2b_seq: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
      compared++;
      if (sent_cnt != 2 || trunc_cnt != 0) begin
         mismatched++;
         $display("FAIL b2b_pulses: sent=%0d trunc=%0d want 2 0", sent_cnt, trunc_cnt);
      end
   endtask

   task automatic test_random();
      int d;
      bit done;
      logic [15:0] pk[6][$];
      clr();
      done = 0;
      for (int p = 0; p < 6; p++) begin
         repeat ($urandom_range(1, 11)) pk[p].push_back(16'($urandom));
         expect_pkt(pk[p]);
      end
      fork
         begin
            for (int p = 0; p < 6; p++) send_pkt(pk[p], 1);
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge wclk); #1;
               fifo_full = $urandom_range(0, 2) == 0;
            end
            fifo_full = 0;
         end
      join
      wait_drain();
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL rand_seq: got %0d words (w[%0d]=%h), want %0d (w=%h)", got.size(), d, d >= 0 ? got[d] : 16'h0, exp.size(), d >= 0 ? exp[d] : 16'h0);
      end
      compared++;
      if (sent_cnt != exp_sent || trunc_cnt != exp_trunc || pair_bad != 0 || viol != 0) begin
         mismatched++;
         $display("FAIL rand_pulses: sent=%0d trunc=%0d unpaired=%0d viol=%0d want %0d %0d 0 0", sent_cnt, trunc_cnt, pair_bad, viol, exp_sent, exp_trunc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four();
      test_stall();
      test_trunc();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
